// File: rtl/microwave_timer_ctrl.sv
// Microwave top-level controller: countdown cook timer with one-second prescaler,
// duty-cycled magnetron power, timed bell and add-time on re-press of start.
module microwave_timer_ctrl #(
   parameter int TIME_W     = 8,
   parameter int TICK_DIV   = 100,
   parameter int PWR_LEVELS = 4,
   parameter int BELL_TICKS = 3,
   parameter int ADD_TIME   = 30,
   parameter int PWR_W      = $clog2(PWR_LEVELS + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              door,
   input  logic              start,
   input  logic              stop,
   input  logic [TIME_W-1:0] time_in,
   input  logic [PWR_W-1:0]  power_in,
   output logic              heat,
   output logic              light,
   output logic              bell,
   output logic [TIME_W-1:0] remaining,
   output logic [2:0]        state_o
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BELL_W  = $clog2(BELL_TICKS + 1);
   localparam int ACC_W   = TIME_W + 32;
   localparam logic [TIME_W-1:0] TIME_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COOK  = 3'd1,
      S_PAUSE = 3'd2,
      S_BELL  = 3'd3,
      S_OPEN  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [TIME_W-1:0]   remaining_q, remaining_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PWR_W-1:0]    phase_q, phase_d;
   logic [PWR_W-1:0]    power_q, power_d;
   logic [BELL_W-1:0]   bell_cnt_q, bell_cnt_d;
   logic                tick;

   // remaining - tick + add*ADD_TIME, clamped to the counter range; never wraps below 0
   function automatic logic [TIME_W-1:0] sat_time(input logic [TIME_W-1:0] r,
                                                  input logic dec,
                                                  input logic add);
      logic [ACC_W-1:0] acc;
      acc = ACC_W'(r);
      if (dec && (r != '0))
         acc = acc - ACC_W'(1);
      if (add)
         acc = acc + ACC_W'(ADD_TIME);
      if (acc > ACC_W'(TIME_MAX))
         return TIME_MAX;
      return acc[TIME_W-1:0];
   endfunction

   function automatic logic [PWR_W-1:0] clamp_power(input logic [PWR_W-1:0] p);
      if (p == '0)
         return PWR_W'(1);
      if (p > PWR_W'(PWR_LEVELS))
         return PWR_W'(PWR_LEVELS);
      return p;
   endfunction

   assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         presc_q     <= '0;
         phase_q     <= '0;
         power_q     <= '0;
         bell_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         presc_q     <= presc_d;
         phase_q     <= phase_d;
         power_q     <= power_d;
         bell_cnt_q  <= bell_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      presc_d     = presc_q;
      phase_d     = phase_q;
      power_d     = power_q;
      bell_cnt_d  = bell_cnt_q;

      case (state_q)
         S_IDLE: begin
            // stop outranks start, so a simultaneous stop swallows the start
            if (door) begin
               state_d = S_OPEN;
            end else if (!stop && start && (time_in != '0)) begin
               state_d     = S_COOK;
               remaining_d = time_in;
               presc_d     = '0;
               phase_d     = '0;
               power_d     = clamp_power(power_in);
            end
         end

         S_COOK: begin
            if (door) begin
               state_d = S_PAUSE;
            end else if (stop) begin
               state_d     = S_IDLE;
               remaining_d = '0;
            end else begin
               presc_d = tick ? '0 : presc_q + PRESC_W'(1);
               if (tick)
                  phase_d = (phase_q == PWR_W'(PWR_LEVELS - 1)) ? '0 : phase_q + PWR_W'(1);
               // an add-time request on the final tick keeps cooking instead of ringing
               if (tick && (remaining_q == TIME_W'(1)) && !start) begin
                  state_d     = S_BELL;
                  remaining_d = '0;
                  bell_cnt_d  = '0;
                  presc_d     = '0;
               end else begin
                  remaining_d = sat_time(remaining_q, tick, start);
               end
            end
         end

         S_PAUSE: begin
            if (door) begin
               if (stop) begin
                  state_d     = S_OPEN;
                  remaining_d = '0;
               end
            end else if (stop) begin
               state_d     = S_IDLE;
               remaining_d = '0;
            end else if (start) begin
               state_d = S_COOK;
            end
         end

         S_BELL: begin
            if (door) begin
               state_d = S_OPEN;
            end else if (stop) begin
               state_d = S_IDLE;
            end else begin
               presc_d = tick ? '0 : presc_q + PRESC_W'(1);
               if (tick) begin
                  if (bell_cnt_q == BELL_W'(BELL_TICKS - 1))
                     state_d = S_IDLE;
                  else
                     bell_cnt_d = bell_cnt_q + BELL_W'(1);
               end
            end
         end

         S_OPEN: begin
            if (!door)
               state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode registered state only; unused codes fall through to all-off.
   assign light     = (state_q == S_COOK) || (state_q == S_PAUSE) || (state_q == S_OPEN);
   assign bell      = (state_q == S_BELL);
   assign heat      = (state_q == S_COOK) && (phase_q < power_q);
   assign remaining = remaining_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl: a table of cycle-counted vectors
// followed by hand-written pause, saturation and async-reset sequences.
module tb_microwave_timer_ctrl;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] COOK  = 3'd1;
   localparam logic [2:0] PAUSE = 3'd2;
   localparam logic [2:0] BELL  = 3'd3;
   localparam logic [2:0] OPEN  = 3'd4;

   logic       clk;
   logic       nrst;
   logic       door;
   logic       start;
   logic       stop;
   logic [7:0] time_in;
   logic [2:0] power_in;
   logic       heat;
   logic       light;
   logic       bell;
   logic [7:0] remaining;
   logic [2:0] state_o;

   int errors = 0;
   int checks = 0;

   microwave_timer_ctrl #(
      .TIME_W    (8),
      .TICK_DIV  (4),
      .PWR_LEVELS(4),
      .BELL_TICKS(2),
      .ADD_TIME  (5)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .door     (door),
      .start    (start),
      .stop     (stop),
      .time_in  (time_in),
      .power_in (power_in),
      .heat     (heat),
      .light    (light),
      .bell     (bell),
      .remaining(remaining),
      .state_o  (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       door;
      logic       start;
      logic       stop;
      logic [7:0] tin;
      logic [2:0] pin;
      int         ncyc;
      logic [2:0] st;
      logic       heat;
      logic       light;
      logic       bell;
      logic [7:0] rem;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic d, input logic s, input logic p,
                      input logic [7:0] t, input logic [2:0] pw, input int n,
                      input logic [2:0] es, input logic eh, input logic el,
                      input logic eb, input logic [7:0] er);
      vec_t v;
      v.name = nm; v.door = d; v.start = s; v.stop = p; v.tin = t; v.pin = pw;
      v.ncyc = n; v.st = es; v.heat = eh; v.light = el; v.bell = eb; v.rem = er;
      vecs.push_back(v);
   endtask

   // Advance n rising edges; start/stop are single-cycle pulses.
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         stop  = 1'b0;
      end
   endtask

   task automatic check(input string nm, input logic [2:0] es, input logic eh,
                        input logic el, input logic eb, input logic [7:0] er);
      checks++;
      if (state_o !== es || heat !== eh || light !== el || bell !== eb || remaining !== er) begin
         errors++;
         $display("FAIL %s: got state=%0d heat=%b light=%b bell=%b rem=%0d, expected state=%0d heat=%b light=%b bell=%b rem=%0d",
                  nm, state_o, heat, light, bell, remaining, es, eh, el, eb, er);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; door = 1'b0; start = 1'b0; stop = 1'b0;
      time_in = '0; power_in = '0;

      //            name        door st sp tin pin n  state  h  l  b  rem
      add("t1_start",     0, 1, 0,   3, 4, 1, COOK,  1, 1, 0,   3);
      add("t1_pre_tick",  0, 0, 0,   0, 0, 3, COOK,  1, 1, 0,   3);
      add("t1_tick1",     0, 0, 0,   0, 0, 1, COOK,  1, 1, 0,   2);
      add("t1_tick2",     0, 0, 0,   0, 0, 4, COOK,  1, 1, 0,   1);
      add("t1_cyc11",     0, 0, 0,   0, 0, 3, COOK,  1, 1, 0,   1);
      add("t1_bell_on",   0, 0, 0,   0, 0, 1, BELL,  0, 0, 1,   0);
      add("t1_bell_last", 0, 0, 0,   0, 0, 7, BELL,  0, 0, 1,   0);
      add("t1_bell_done", 0, 0, 0,   0, 0, 1, IDLE,  0, 0, 0,   0);

      add("t2_start",     0, 1, 0,   8, 1, 1, COOK,  1, 1, 0,   8);
      add("t2_cyc3",      0, 0, 0,   0, 0, 3, COOK,  1, 1, 0,   8);
      add("t2_phase1",    0, 0, 0,   0, 0, 1, COOK,  0, 1, 0,   7);
      add("t2_cyc15",     0, 0, 0,   0, 0, 11, COOK, 0, 1, 0,   5);
      add("t2_phase0",    0, 0, 0,   0, 0, 1, COOK,  1, 1, 0,   4);
      add("t2_cyc20",     0, 0, 0,   0, 0, 4, COOK,  0, 1, 0,   3);
      add("t2_cyc31",     0, 0, 0,   0, 0, 11, COOK, 0, 1, 0,   1);
      add("t2_stop",      0, 0, 1,   0, 0, 1, IDLE,  0, 0, 0,   0);

      add("pw0_start",    0, 1, 0,   2, 0, 1, COOK,  1, 1, 0,   2);
      add("pw0_phase1",   0, 0, 0,   0, 0, 4, COOK,  0, 1, 0,   1);
      add("pw0_stop",     0, 0, 1,   0, 0, 1, IDLE,  0, 0, 0,   0);
      add("pw7_start",    0, 1, 0,   2, 7, 1, COOK,  1, 1, 0,   2);
      add("pw7_phase1",   0, 0, 0,   0, 0, 4, COOK,  1, 1, 0,   1);
      add("pw7_bell",     0, 0, 0,   0, 0, 4, BELL,  0, 0, 1,   0);
      add("bell_door",    1, 0, 0,   0, 0, 1, OPEN,  0, 1, 0,   0);
      add("bell_close",   0, 0, 0,   0, 0, 1, IDLE,  0, 0, 0,   0);

      add("t5_zero_time", 0, 1, 0,   0, 2, 1, IDLE,  0, 0, 0,   0);
      add("t5_idle_stop", 0, 0, 1,   0, 0, 1, IDLE,  0, 0, 0,   0);
      add("t5_open",      1, 0, 0,   0, 0, 1, OPEN,  0, 1, 0,   0);
      add("t5_open_start",1, 1, 0,   9, 2, 1, OPEN,  0, 1, 0,   0);
      add("t5_open_stop", 1, 0, 1,   0, 0, 1, OPEN,  0, 1, 0,   0);
      add("t5_close",     0, 0, 0,   0, 0, 1, IDLE,  0, 0, 0,   0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", IDLE, 0, 0, 0, 0);
      nrst = 1'b1;

      foreach (vecs[i]) begin
         door     = vecs[i].door;
         start    = vecs[i].start;
         stop     = vecs[i].stop;
         time_in  = vecs[i].tin;
         power_in = vecs[i].pin;
         run(vecs[i].ncyc);
         check(vecs[i].name, vecs[i].st, vecs[i].heat, vecs[i].light, vecs[i].bell, vecs[i].rem);
      end

      // Pause mid-interval: prescaler holds at 2, so resume ticks after 2 edges.
      time_in = 8'd3; power_in = 3'd4; start = 1'b1;
      run(1);
      run(4);
      check("t3_tick1", COOK, 1, 1, 0, 2);
      run(2);
      door = 1'b1;
      run(1);
      check("t3_pause", PAUSE, 0, 1, 0, 2);
      start = 1'b1;
      run(1);
      check("t3_start_door_open", PAUSE, 0, 1, 0, 2);
      door = 1'b0;
      run(3);
      check("t3_door_closed", PAUSE, 0, 1, 0, 2);
      start = 1'b1;
      run(1);
      check("t3_resume", COOK, 1, 1, 0, 2);
      run(1);
      check("t3_resume_pre", COOK, 1, 1, 0, 2);
      run(1);
      check("t3_resume_tick", COOK, 1, 1, 0, 1);
      stop = 1'b1;
      run(1);
      check("t3_stop", IDLE, 0, 0, 0, 0);

      // Add-time saturation, then add-time on the final tick.
      time_in = 8'd253; power_in = 3'd4; start = 1'b1;
      run(1);
      check("t4_load253", COOK, 1, 1, 0, 253);
      start = 1'b1;
      run(1);
      check("t4_saturate", COOK, 1, 1, 0, 255);
      stop = 1'b1;
      run(1);
      check("t4_stop", IDLE, 0, 0, 0, 0);
      time_in = 8'd1; start = 1'b1;
      run(1);
      run(3);
      check("t4_pre_final", COOK, 1, 1, 0, 1);
      start = 1'b1;
      run(1);
      check("t4_add_on_final", COOK, 1, 1, 0, 5);
      run(4);
      check("t4_next_tick", COOK, 1, 1, 0, 4);
      stop = 1'b1;
      run(1);
      check("t4_stop2", IDLE, 0, 0, 0, 0);

      // Asynchronous reset mid-cook, observed between clock edges.
      time_in = 8'd7; power_in = 3'd4; start = 1'b1;
      run(1);
      check("t6_cook", COOK, 1, 1, 0, 7);
      #2;
      nrst = 1'b0;
      #1;
      check("t6_async_reset", IDLE, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      run(12);
      check("t6_after_release", IDLE, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Microwave controller with an integrated countdown cook timer, duty-cycled power levels, a timed bell and add-time on re-press of start.
- A clock prescaler produces one-second ticks.
- The controller drives the heater, lamp and bell, and exposes the remaining time for a display block.
- It is the top control FSM of the appliance: inputs come from debounced panel/door logic, outputs go to the actuator drivers.

Parameters:
TIME_W, 8, width of cook-time counter in seconds; max = 2^TIME_W-1
TICK_DIV, 100, clk cycles per one-second tick (>=2)
PWR_LEVELS, 4, number of power levels; also the duty window length in ticks
BELL_TICKS, 3, bell duration in ticks (>=1)
ADD_TIME, 30, seconds added by start while cooking
PWR_W, $clog2(PWR_LEVELS+1), width of power_in (derived)

Ports:
clk  in  1  clock, all state changes on rising edge
nrst  in  1  asynchronous active-low reset
door  in  1  1 = door open
start  in  1  single-cycle start / add-time / resume request
stop  in  1  single-cycle cancel request
time_in  in  TIME_W  requested cook time in seconds, sampled on accepted start in IDLE
power_in  in  PWR_W  requested power level, sampled with time_in
heat  out  1  magnetron enable
light  out  1  cavity lamp
bell  out  1  bell driver
remaining  out  TIME_W  seconds left (registered)
state_o  out  3  current state: IDLE=0, COOK=1, PAUSE=2, BELL=3, OPEN=4

Behaviour:
- Reset (nrst low, async): state IDLE; remaining, prescaler, phase, bell count and power_q all 0; heat/light/bell 0 immediately.
- Input priority every cycle: door > stop > start.
- Outputs are combinational from registered state only:
  - light = COOK|PAUSE|OPEN
  - bell = BELL
  - heat = COOK & (phase < power_q)
- Prescaler:
  - Counts 0..TICK_DIV-1 in COOK and BELL only; tick = (prescaler==TICK_DIV-1).
  - Wraps to 0 on tick; holds its value in PAUSE.
  - Cleared to 0 on entry to COOK from IDLE and on entry to BELL.
  - First tick occurs TICK_DIV cycles after start is accepted.
- Phase counter:
  - 0..PWR_LEVELS-1; increments on each COOK tick, wraps to 0.
  - Cleared on start accepted in IDLE.
  - Heat is on for power_q ticks out of every PWR_LEVELS.
- power_q is latched on start accepted in IDLE:
  - power_in==0 → 1
  - power_in>PWR_LEVELS → PWR_LEVELS
  - otherwise power_in
- IDLE:
  - door → OPEN.
  - start & time_in!=0 → COOK; load remaining=time_in.
  - start with time_in==0 is ignored (stay IDLE).
  - stop is a no-op.
- COOK:
  - door → PAUSE; the tick on that edge is suppressed (prescaler and remaining hold).
  - stop → IDLE, remaining←0.
  - Otherwise remaining←sat(remaining − tick + start·ADD_TIME), saturating at 2^TIME_W−1.
  - If tick & remaining==1 & !start → remaining←0, state←BELL, bell count←0.
  - If start coincides with the final tick, cooking continues with remaining=ADD_TIME.
- PAUSE:
  - heat 0, light 1; stays in PAUSE even when the door closes (no auto-resume).
  - !door & start → COOK; prescaler, phase and remaining resume from held values.
  - stop → OPEN if door, else IDLE; remaining←0.
  - start while door open is ignored.
- BELL:
  - Bell count increments on tick; after BELL_TICKS ticks (BELL_TICKS·TICK_DIV cycles) → IDLE.
  - door → OPEN; stop → IDLE; start is ignored.
- OPEN:
  - !door → IDLE; start and stop are ignored.
- Unreachable state codes (5–7) → IDLE on the next edge with all outputs 0.
- Reset asserted mid-cook aborts immediately; no bell is produced after reset release.

Test Plan:
(TICK_DIV=4, PWR_LEVELS=4, BELL_TICKS=2, ADD_TIME=5, TIME_W=8)
1. time_in=3, power_in=4, start → heat=light=1 for 12 cycles; remaining 3→2→1→0 at cycles 4/8/12; bell=1 for 8 cycles; then state_o=0 and all outputs 0.
2. time_in=8, power_in=1, start → heat=1 only during phase 0 (cycles 1–4 and 17–20); heat=0 for cycles 5–16 and 21–32; light=1 throughout.
3. Cooking, remaining=2, door=1 two cycles after a tick → PAUSE, heat=0, light=1, remaining=2 held. Door closes → stays PAUSE. start → COOK; the next tick arrives 2 cycles later with remaining 2→1.
4. remaining=253 in COOK, start → remaining=255 (saturated). start on the same edge as the final tick at remaining=1 → remaining=5, state stays COOK, no bell.
5. IDLE, start with time_in=0 → stays IDLE. door=1 → OPEN, light=1. start while OPEN → stays OPEN. Door closes → IDLE.
6. nrst=0 mid-COOK with remaining=7 → heat/light/bell=0, remaining=0, state_o=0 without waiting for a clk edge. Release nrst → stays IDLE.
